fetch_unit: RTL

//  Program-counter/fetch stage directly upstream of the control decoder. Holds PC, drives

---
 rtl/fetch_unit_pkg.sv | 13 +
 rtl/fetch_unit_branch_lut.sv | 32 +++
 rtl/fetch_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the fetch stage
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_RUN    = 2'd1,
    FS_HALTED = 2'd2
  } fetch_state_t;

  localparam int LBL_N = 16;
  localparam int LBL_W = 4;

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// rtl/fetch_unit_branch_lut.sv - branch-target table, registered write, combinational read
module branch_lut
  import fetch_unit_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [LBL_W-1:0] widx,
  input  logic [PC_W-1:0]  wdata,
  input  logic [LBL_W-1:0] ridx,
  output logic [PC_W-1:0]  rdata
);

  logic [PC_W-1:0] mem [LBL_N];

  // Clear every entry on reset so unwritten labels resolve to address 0; otherwise accept writes
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LBL_N; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Same-cycle read lets a taken branch redirect the PC with no bubble
  assign rdata = mem[ridx];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, run/halt control and retired-instruction counter
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             BranchEn,
  input  logic [LBL_W-1:0] label_index,
  input  logic             Halt,
  input  logic             lut_we,
  input  logic [LBL_W-1:0] lut_idx,
  input  logic [PC_W-1:0]  lut_data,
  output logic [PC_W-1:0]  PC,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] instr_count
);

  fetch_state_t    state, state_next;
  logic            start_q;
  logic            start_rise;
  logic            lut_wr_ok;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] lut_rdata;

  assign start_rise = Start & ~start_q;
  // The table is frozen while a program executes
  assign lut_wr_ok  = lut_we & (state != FS_RUN);

  branch_lut #(
    .PC_W (PC_W)
  ) u_branch_lut (
    .clk   (Clk),
    .reset (Reset),
    .we    (lut_wr_ok),
    .widx  (lut_idx),
    .wdata (lut_data),
    .ridx  (label_index),
    .rdata (lut_rdata)
  );

  // Previous Start level; sampled through reset so a Start held across reset is not an edge
  always_ff @(posedge Clk) begin
    start_q <= Start;
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= FS_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and next PC: Halt beats BranchEn beats sequential fetch
  always_comb begin
    state_next = state;
    pc_next    = PC;
    case (state)
      FS_IDLE, FS_HALTED: begin
        if (start_rise) begin
          state_next = FS_RUN;
          pc_next    = '0;
        end
      end
      FS_RUN: begin
        if (Halt) begin
          state_next = FS_HALTED;
        end else if (BranchEn) begin
          pc_next = lut_rdata;
        end else begin
          pc_next = PC + 1'b1;
        end
      end
      default: begin
        state_next = FS_IDLE;
        pc_next    = '0;
      end
    endcase
  end

  // PC and registered state decodes for Running/Done
  always_ff @(posedge Clk) begin
    if (Reset) begin
      PC      <= '0;
      Running <= 1'b0;
      Done    <= 1'b0;
    end else begin
      PC      <= pc_next;
      Running <= (state_next == FS_RUN);
      Done    <= (state_next == FS_HALTED);
    end
  end

  // Retired-instruction counter: cleared on a new run, saturating while running
  always_ff @(posedge Clk) begin
    if (Reset) begin
      instr_count <= '0;
    end else if (state != FS_RUN) begin
      if (start_rise) begin
        instr_count <= '0;
      end
    end else if (instr_count != {CNT_W{1'b1}}) begin
      instr_count <= instr_count + 1'b1;
    end
  end

endmodule
